serial_adder_acc: RTL and testbench
===================================

Name: serial_adder_acc

Overview:
- Parametrised multi-cycle adder/subtractor/accumulator. It is the next generation of the single-bit full-adder cell.
- Processes a WIDTH-bit add or subtract CHUNK bits per clock, LSB slice first, through one CHUNK-bit ripple slice.
- Holds the result in an accumulator register, so successive operations can chain.
- Used where a full-width single-cycle adder costs too much area or timing; a start/ready/done handshake sequences it.

Parameters:
- WIDTH, 16, operand and result width in bits.
- CHUNK, 4, bits processed per cycle. Must divide WIDTH exactly. CHUNK = WIDTH gives single-cycle operation.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RST_N  in  1  asynchronous active-low reset.
- START  in  1  request a new operation; accepted only when READY = 1.
- OP  in  2  operation select: 00 S=A+B+CIN; 01 S=A-B; 10 S=S+B+CIN; 11 S=S-B.
- A  in  WIDTH  first operand; ignored when OP[1] = 1.
- B  in  WIDTH  second operand.
- CIN  in  1  carry-in for OP 00 and 10; ignored for subtract.
- READY  out  1  high when idle and able to accept START.
- DONE  out  1  one-cycle pulse when S, COUT and OVF update.
- S  out  WIDTH  result/accumulator register.
- COUT  out  1  carry-out of the last operation. For subtract, 1 means no borrow.
- OVF  out  1  two's-complement signed overflow of the last operation.

Behaviour:
- Reset (RST_N low, asynchronous):
  - Outputs go to S = 0, COUT = 0, OVF = 0, DONE = 0, READY = 1; state = IDLE.
  - An in-flight operation is aborted with no partial result kept.
- States: IDLE, BUSY. Let NCH = WIDTH/CHUNK.
- IDLE:
  - READY = 1.
  - On an edge with START = 1, the block captures:
    - X = OP[1] ? S : A
    - Y = OP[0] ? ~B : B
    - carry = OP[0] ? 1 : CIN
  - The slice counter clears and the state goes to BUSY.
- BUSY:
  - READY = 0.
  - Each cycle, slice i (bits i*CHUNK .. i*CHUNK+CHUNK-1) computes X_slice + Y_slice + carry. The sum goes into an internal result register and the carry is registered for the next slice.
  - After slice NCH-1 is processed on an edge:
    - S is loaded with the full result.
    - COUT = final carry.
    - OVF = carry into MSB XOR carry out of MSB.
    - DONE = 1 for exactly that following cycle; state returns to IDLE.
- Latency: START sampled at edge k gives DONE high and the new S visible after edge k+NCH. READY is high again in the same cycle as DONE.
- Back-to-back: START held high in the DONE cycle is accepted, so the throughput is one operation per NCH cycles.
- S, COUT and OVF change only on a completion edge. They are stable while BUSY and while idle.
- Accumulate (OP 1x) uses the S value as it is at the START edge, including a value just written on that same DONE cycle.
- START while READY = 0 is ignored: no queueing, no error. Inputs are not sampled after the START edge, so A, B and OP may change during BUSY.
- Arithmetic is modulo 2^WIDTH. No saturation; overflow is reported only through OVF.
- CHUNK = WIDTH: BUSY lasts one cycle and DONE comes one cycle after START.

Test Plan:
- Plain add, WIDTH=16, CHUNK=4, OP=00, A=0x1234, B=0x0FFF, CIN=0 -> DONE exactly 4 cycles after START; S=0x2233, COUT=0, OVF=0; READY low for those 4 cycles.
- Signed overflow: OP=00, A=0x7FFF, B=0x0001, CIN=0 -> S=0x8000, OVF=1, COUT=0. Then A=0xFFFF, B=0x0001 -> S=0x0000, COUT=1, OVF=0.
- Subtract: OP=01, A=0x0000, B=0x0001 -> S=0xFFFF, COUT=0 (borrow), OVF=0. Then A=0x8000, B=0x0001 -> S=0x7FFF, OVF=1, COUT=1.
- Accumulate chain, back-to-back:
  - START OP=00, A=0x0005, B=0, CIN=0.
  - START OP=10, B=0x0003 held in that op's DONE cycle -> S=0x0008.
  - Then OP=11, B=0x0009 -> S=0xFFFF, COUT=0.
  - Second op's DONE exactly 4 cycles after the first's.
- START pulsed in the 2nd BUSY cycle with different operands -> ignored; the first result is unaffected and no extra DONE appears.
- RST_N low in the 3rd BUSY cycle (asynchronous, mid-clock) -> S=0 and READY=1 immediately; no DONE follows. With CHUNK=16, an add gives DONE one cycle after START.

Source files
------------

// File: rtl/serial_adder_acc.sv
// Purpose: multi-cycle add/subtract/accumulate, CHUNK bits per cycle through one ripple slice.
// Latency: START sampled at edge k -> DONE pulse, new S/COUT/OVF visible after edge k+WIDTH/CHUNK.
// Backpressure: READY low while busy; START with READY low is dropped (no queueing).
//
// Ports:
//   CLK, RST_N      clock, asynchronous active-low reset
//   START, OP, A, B, CIN   operation request (OP: 00 A+B+CIN, 01 A-B, 10 S+B+CIN, 11 S-B)
//   READY           idle and able to accept START
//   DONE            one-cycle pulse when S/COUT/OVF update
//   S, COUT, OVF    result/accumulator, carry-out (1 = no borrow on subtract), signed overflow
module serial_adder_acc #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             START,
    input  logic [1:0]       OP,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             CIN,
    output logic             READY,
    output logic             DONE,
    output logic [WIDTH-1:0] S,
    output logic             COUT,
    output logic             OVF
);

    localparam int NCH = WIDTH / CHUNK;
    localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int IW  = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(NCH - 1);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt;
    logic [IW-1:0]   base;
    logic [WIDTH-1:0] x_q, y_q, res_q, res_nxt;
    logic            carry_q;
    logic [CHUNK-1:0] x_sl, y_sl;
    logic [CHUNK:0]  sl_sum;
    logic            msb_cin;
    logic            accept;
    logic            last;

    assign accept = (state == IDLE) && START;
    assign last   = (state == BUSY) && (cnt == LAST);

    // Slice datapath: one CHUNK-bit ripple add on the slice selected by the counter.
    always_comb begin
        base    = IW'(cnt) * IW'(CHUNK);
        x_sl    = x_q[base +: CHUNK];
        y_sl    = y_q[base +: CHUNK];
        sl_sum  = {1'b0, x_sl} + {1'b0, y_sl} + {{CHUNK{1'b0}}, carry_q};
        res_nxt = res_q;
        res_nxt[base +: CHUNK] = sl_sum[CHUNK-1:0];
        // Carry into the slice MSB recovered from its sum bit: s = x ^ y ^ cin.
        msb_cin = sl_sum[CHUNK-1] ^ x_sl[CHUNK-1] ^ y_sl[CHUNK-1];
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        READY     = 1'b0;
        case (state)
            IDLE: begin
                READY = 1'b1;
                if (START) begin
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (cnt == LAST) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cnt     <= '0;
            x_q     <= '0;
            y_q     <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            S       <= '0;
            COUT    <= 1'b0;
            OVF     <= 1'b0;
            DONE    <= 1'b0;
        end else begin
            DONE <= 1'b0;
            if (accept) begin
                // Accumulate reads S as registered now, including a result written on this DONE cycle.
                x_q     <= OP[1] ? S : A;
                // Subtract is X + ~B + 1.
                y_q     <= OP[0] ? ~B : B;
                carry_q <= OP[0] | CIN;
                cnt     <= '0;
            end else if (state == BUSY) begin
                res_q   <= res_nxt;
                carry_q <= sl_sum[CHUNK];
                cnt     <= cnt + CW'(1);
                if (last) begin
                    S    <= res_nxt;
                    COUT <= sl_sum[CHUNK];
                    OVF  <= msb_cin ^ sl_sum[CHUNK];
                    DONE <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_serial_adder_acc.sv
module tb_serial_adder_acc;

    localparam int NCH1 = 4;
    localparam int NCH2 = 1;

    logic        clk = 1'b0;
    logic        rst_n, start1, start2, cin;
    logic [1:0]  op;
    logic [15:0] a, b;
    logic        ready1, done1, cout1, ovf1;
    logic        ready2, done2, cout2, ovf2;
    logic [15:0] s1, s2;

    int tests = 0;
    int fails = 0;
    int edge_cnt = 0;
    int done_cnt1 = 0;
    int done_cnt2 = 0;
    int last_done1 = 0;

    typedef struct {
        logic [15:0] s;
        logic        cout;
        logic        ovf;
        int          due;
    } exp_t;

    exp_t        q1[$];
    exp_t        q2[$];
    logic [15:0] model_s[2];

    always #5 clk = ~clk;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    serial_adder_acc #(.WIDTH(16), .CHUNK(4)) u_dut1 (
        .CLK(clk), .RST_N(rst_n), .START(start1), .OP(op), .A(a), .B(b), .CIN(cin),
        .READY(ready1), .DONE(done1), .S(s1), .COUT(cout1), .OVF(ovf1)
    );

    serial_adder_acc #(.WIDTH(16), .CHUNK(16)) u_dut2 (
        .CLK(clk), .RST_N(rst_n), .START(start2), .OP(op), .A(a), .B(b), .CIN(cin),
        .READY(ready2), .DONE(done2), .S(s2), .COUT(cout2), .OVF(ovf2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the operation's meaning.
    function automatic exp_t model(input logic [1:0] o, input logic [15:0] aa, input logic [15:0] bb,
                                   input logic [15:0] ss, input logic ci, input int due);
        logic [15:0] x;
        int          sx, sb, sv, ux;
        exp_t        e;
        x  = o[1] ? ss : aa;
        sx = $signed(x);
        sb = $signed(bb);
        if (!o[0]) begin
            ux     = int'(x) + int'(bb) + int'(ci);
            e.s    = ux[15:0];
            e.cout = ux[16];
            sv     = sx + sb + int'(ci);
        end else begin
            e.s    = x - bb;
            e.cout = (x >= bb);
            sv     = sx - sb;
        end
        e.ovf = (sv > 32767) || (sv < -32768);
        e.due = due;
        return e;
    endfunction

    always @(negedge clk) begin
        if (rst_n && done1) begin
            exp_t e;
            done_cnt1++;
            last_done1 = edge_cnt;
            if (q1.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL dut1 unexpected DONE at edge %0d, expected none", edge_cnt);
            end else begin
                e = q1.pop_front();
                check("dut1 S", s1, e.s);
                check("dut1 COUT", cout1, e.cout);
                check("dut1 OVF", ovf1, e.ovf);
                check("dut1 DONE edge", edge_cnt, e.due);
                check("dut1 READY with DONE", ready1, 1);
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && done2) begin
            exp_t e;
            done_cnt2++;
            if (q2.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL dut2 unexpected DONE at edge %0d, expected none", edge_cnt);
            end else begin
                e = q2.pop_front();
                check("dut2 S", s2, e.s);
                check("dut2 COUT", cout2, e.cout);
                check("dut2 OVF", ovf2, e.ovf);
                check("dut2 DONE edge", edge_cnt, e.due);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Waits for READY, presents one operation for one edge and records its expected result.
    task automatic issue(input int sel, input logic [1:0] o, input logic [15:0] aa,
                         input logic [15:0] bb, input logic ci);
        int   n;
        exp_t e;
        n = 0;
        while (((sel == 0) ? ready1 : ready2) !== 1'b1 && n < 60) begin
            step(1);
            n++;
        end
        if (n >= 60) begin
            tests++;
            fails++;
            $display("FAIL issue dut%0d: READY stayed 0, expected 1", sel + 1);
            return;
        end
        op  = o;
        a   = aa;
        b   = bb;
        cin = ci;
        e = model(o, aa, bb, model_s[sel], ci, edge_cnt + 1 + ((sel == 0) ? NCH1 : NCH2));
        model_s[sel] = e.s;
        if (sel == 0) begin
            q1.push_back(e);
            start1 = 1'b1;
        end else begin
            q2.push_back(e);
            start2 = 1'b1;
        end
        step(1);
        start1 = 1'b0;
        start2 = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((q1.size() != 0 || q2.size() != 0) && n < 200) begin
            step(1);
            n++;
        end
        tests++;
        if (n >= 200) begin
            fails++;
            $display("FAIL wait_idle: %0d/%0d results still pending, expected 0", q1.size(), q2.size());
            q1.delete();
            q2.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int          dc;
        logic [1:0]  r_op;
        logic [15:0] r_a, r_b;
        int          r_sel;

        rst_n  = 1'b0;
        start1 = 1'b0;
        start2 = 1'b0;
        op     = 2'b00;
        a      = '0;
        b      = '0;
        cin    = 1'b0;
        model_s[0] = '0;
        model_s[1] = '0;
        step(3);
        check("reset S", s1, 0);
        check("reset COUT", cout1, 0);
        check("reset OVF", ovf1, 0);
        check("reset DONE", done1, 0);
        check("reset READY", ready1, 1);
        check("reset dut2 S", s2, 0);
        check("reset dut2 READY", ready2, 1);
        rst_n = 1'b1;
        step(1);

        // Plain add with READY low for the whole busy window.
        issue(0, 2'b00, 16'h1234, 16'h0FFF, 1'b0);
        for (int i = 0; i < NCH1; i++) begin
            check("busy READY", ready1, 0);
            check("busy DONE", done1, 0);
            step(1);
        end
        check("end READY", ready1, 1);
        check("end DONE", done1, 1);
        wait_idle();
        check("add S", s1, 16'h2233);

        // Signed overflow and unsigned carry.
        issue(0, 2'b00, 16'h7FFF, 16'h0001, 1'b0);
        wait_idle();
        check("ovf S", s1, 16'h8000);
        check("ovf OVF", ovf1, 1);
        check("ovf COUT", cout1, 0);
        issue(0, 2'b00, 16'hFFFF, 16'h0001, 1'b0);
        wait_idle();
        check("carry S", s1, 16'h0000);
        check("carry COUT", cout1, 1);
        check("carry OVF", ovf1, 0);

        // Subtract with borrow, then signed overflow.
        issue(0, 2'b01, 16'h0000, 16'h0001, 1'b0);
        wait_idle();
        check("sub S", s1, 16'hFFFF);
        check("sub COUT", cout1, 0);
        check("sub OVF", ovf1, 0);
        issue(0, 2'b01, 16'h8000, 16'h0001, 1'b0);
        wait_idle();
        check("sub ovf S", s1, 16'h7FFF);
        check("sub ovf OVF", ovf1, 1);
        check("sub ovf COUT", cout1, 1);

        // Accumulate chain, second START in the first op's DONE cycle.
        issue(0, 2'b00, 16'h0005, 16'h0000, 1'b0);
        issue(0, 2'b10, 16'hAAAA, 16'h0003, 1'b0);
        check("b2b accept edge", edge_cnt, last_done1 + 1);
        wait_idle();
        check("acc S", s1, 16'h0008);
        issue(0, 2'b11, 16'h5555, 16'h0009, 1'b0);
        wait_idle();
        check("acc sub S", s1, 16'hFFFF);
        check("acc sub COUT", cout1, 0);

        // START in the 2nd busy cycle is dropped.
        issue(0, 2'b00, 16'h0100, 16'h0200, 1'b0);
        step(1);
        op     = 2'b01;
        a      = 16'hFFFF;
        b      = 16'h1234;
        start1 = 1'b1;
        step(1);
        start1 = 1'b0;
        wait_idle();
        check("ignore S", s1, 16'h0300);
        dc = done_cnt1;
        step(8);
        check("ignore extra DONE", done_cnt1, dc);

        // Asynchronous reset mid-operation.
        issue(0, 2'b00, 16'h1111, 16'h2222, 1'b0);
        step(2);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst S", s1, 0);
        check("arst READY", ready1, 1);
        check("arst DONE", done1, 0);
        check("arst COUT", cout1, 0);
        check("arst OVF", ovf1, 0);
        q1.delete();
        q2.delete();
        model_s[0] = '0;
        model_s[1] = '0;
        dc = done_cnt1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(8);
        check("arst no DONE", done_cnt1, dc);

        // Single-cycle configuration.
        issue(1, 2'b00, 16'h1234, 16'h0FFF, 1'b1);
        check("c16 busy READY", ready2, 0);
        check("c16 busy DONE", done2, 0);
        step(1);
        check("c16 DONE", done2, 1);
        check("c16 S", s2, 16'h2234);
        wait_idle();

        // Randomized traffic on both instances.
        for (int i = 0; i < 80; i++) begin
            r_sel = ($urandom_range(0, 3) == 0) ? 1 : 0;
            r_op  = 2'($urandom_range(0, 3));
            r_a   = 16'($urandom);
            r_b   = 16'($urandom);
            case ($urandom_range(0, 5))
                0: r_b = 16'h8000;
                1: r_a = 16'h7FFF;
                2: r_b = 16'hFFFF;
                default: ;
            endcase
            issue(r_sel, r_op, r_a, r_b, 1'($urandom_range(0, 1)));
            step($urandom_range(0, 2));
        end
        wait_idle();
        check("final dut1 S", s1, model_s[0]);
        check("final dut2 S", s2, model_s[1]);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
